// File: rtl/seg_scan_decoder_pkg.sv
// seg_pkg: shared types, glyph table and anode helpers for the seven-segment scan decoder.
package seg_pkg;
    typedef logic [6:0] seg_t;
    typedef enum logic [1:0] {IDLE, TRACK, LATCHED} state_t;
    localparam int STABLE_CYCLES_DEF = 4;
    localparam int TIMEOUT_CYCLES_DEF = 1024;
    localparam seg_t SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    function automatic logic an_valid(input logic [3:0] an);
        return $onehot(~an);
    endfunction
    function automatic logic [1:0] an_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++)
            if (!an[i]) idx = 2'(i);
        return idx;
    endfunction
endpackage

// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if: display bus observed by the decoder plus its recovered-digit outputs.
interface seg_scan_decoder_if;
    logic [3:0] an;
    seg_pkg::seg_t seven_seg;
    logic dp;
    logic [15:0] hex_out;
    logic [3:0] dp_out;
    logic [3:0] digit_valid;
    logic update;
    logic pattern_err;
    modport master (output an, seven_seg, dp, input hex_out, dp_out, digit_valid, update, pattern_err);
    modport slave (input an, seven_seg, dp, output hex_out, dp_out, digit_valid, update, pattern_err);
endinterface

// File: rtl/seg_pattern_lookup.sv
// seg_pattern_lookup: maps an active-low segment code to its hex value, flagging codes with no glyph.
module seg_pattern_lookup
    import seg_pkg::*;
(
    input  seg_t       seg_i,
    output logic       hit_o,
    output logic [3:0] value_o
);
    always_comb begin
        hit_o = 1'b0;
        value_o = '0;
        for (int g = 0; g < 16; g++)
            if (seg_i == SEG_GLYPH[g]) begin
                hit_o = 1'b1;
                value_o = 4'(g);
            end
    end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: debounces a multiplexed active-low 4-digit display bus and recovers its hex digits.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input logic clk,
    input logic rst,
    seg_scan_decoder_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [11:0] x, s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t state_q, state_d;
    logic [15:0] hex_q;
    logic [3:0] dp_q, valid_q;
    logic upd_q, err_q, same, commit, hold, hit;
    logic [3:0] value;
    logic [1:0] idx;
    logic [TW-1:0] timer_q [4];
    logic [TW-1:0] timer_d [4];
    assign x = {bus.an, bus.seven_seg, bus.dp};
    assign idx = an_index(s_q[11:8]);
    // Decoding the registered sample: at commit it equals the incoming one.
    seg_pattern_lookup u_lookup (.seg_i(s_q[7:1]), .hit_o(hit), .value_o(value));
    always_comb begin
        same = x == s_q;
        cnt_d = !same ? CW'(1) : (cnt_q == CW'(STABLE_CYCLES)) ? cnt_q : cnt_q + CW'(1);
        commit = an_valid(bus.an) && same && state_q == TRACK && cnt_d == CW'(STABLE_CYCLES);
        state_d = !an_valid(bus.an) ? IDLE : !same ? TRACK : commit ? LATCHED :
                  (state_q == LATCHED) ? LATCHED : TRACK;
        hold = state_q == LATCHED && hit;
        for (int d = 0; d < 4; d++)
            timer_d[d] = ((commit || hold) && hit && idx == 2'(d)) ? '0 :
                         (timer_q[d] == TW'(TIMEOUT_CYCLES)) ? timer_q[d] : timer_q[d] + TW'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= '1;
            cnt_q <= '0;
            state_q <= IDLE;
            hex_q <= '0;
            dp_q <= '0;
            valid_q <= '0;
            upd_q <= 1'b0;
            err_q <= 1'b0;
            for (int d = 0; d < 4; d++) timer_q[d] <= '0;
        end else begin
            s_q <= x;
            cnt_q <= cnt_d;
            state_q <= state_d;
            upd_q <= commit && hit;
            err_q <= commit && !hit;
            for (int d = 0; d < 4; d++) begin
                timer_q[d] <= timer_d[d];
                if (commit && hit && idx == 2'(d)) begin
                    valid_q[d] <= 1'b1;
                    hex_q[4*d +: 4] <= value;
                    dp_q[d] <= ~s_q[0];
                end else if (timer_q[d] == TW'(TIMEOUT_CYCLES)) begin
                    valid_q[d] <= 1'b0;
                end
            end
        end
    end
    assign bus.hex_out = hex_q;
    assign bus.dp_out = dp_q;
    assign bus.digit_valid = valid_q;
    assign bus.update = upd_q;
    assign bus.pattern_err = err_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scan-bus stimulus with a scoreboard of expected update/error events.
module tb_seg_scan_decoder;
    localparam int S = 4;
    localparam int T = 1024;
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  valid;
    } ev_t;
    logic clk, rst;
    int tests = 0, fails = 0, cyc = 0;
    ev_t exp_q[$], obs_q[$];
    logic [15:0] m_hex;
    logic [3:0] m_dp, m_valid;
    seg_scan_decoder_if bus ();
    seg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (.clk(clk), .rst(rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (bus.update || bus.pattern_err)
            obs_q.push_back({bus.pattern_err, bus.update, 32'(cyc), bus.hex_out, bus.dp_out, bus.digit_valid});
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask
    task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        bus.an = a;
        bus.seven_seg = s;
        bus.dp = d;
        repeat (n) @(posedge clk);
        #1;
    endtask
    // kind 1 = update (model refreshed), kind 2 = pattern error; the event lands S edges after the drive.
    task automatic push_ev(input logic [1:0] kind, input int digit, input logic [3:0] val, input logic dpv);
        if (kind == 2'd1) begin
            m_hex[4*digit +: 4] = val;
            m_dp[digit] = dpv;
            m_valid[digit] = 1'b1;
        end
        exp_q.push_back({kind, 32'(cyc + S), m_hex, m_dp, m_valid});
    endtask
    task automatic check_events(input string tag);
        ev_t e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            chk({tag, "_event"}, o, e);
        end
        chk({tag, "_extra_events"}, obs_q.size(), 0);
        obs_q.delete();
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_hex"}, bus.hex_out, 16'h0);
        chk({tag, "_dp"}, bus.dp_out, 4'h0);
        chk({tag, "_valid"}, bus.digit_valid, 4'h0);
        chk({tag, "_update"}, bus.update, 1'b0);
        chk({tag, "_err"}, bus.pattern_err, 1'b0);
    endtask
    initial begin
        logic [6:0] g [4];
        logic [3:0] v [4];
        g = '{7'h12, 7'h08, 7'h46, 7'h0E};
        v = '{4'h5, 4'hA, 4'hC, 4'hF};
        m_hex = '0;
        m_dp = '0;
        m_valid = '0;
        rst = 1'b1;
        drive(4'hF, 7'h7F, 1'b1, 2);
        chk_zero("reset");
        rst = 1'b0;
        push_ev(2'd1, 0, 4'h0, 1'b0);
        drive(4'hE, 7'h40, 1'b1, 6);
        drive(4'hF, 7'h7F, 1'b1, 3);
        check_events("single");
        chk("single_hex", bus.hex_out[3:0], 4'h0);
        chk("single_valid", bus.digit_valid, 4'b0001);
        chk("single_dp", bus.dp_out, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            push_ev(2'd1, i, v[i], i == 2);
            drive(~(4'b0001 << i), g[i], (i == 2) ? 1'b0 : 1'b1, 8);
        end
        drive(4'hF, 7'h7F, 1'b1, 3);
        check_events("scan");
        chk("scan_hex", bus.hex_out, 16'hFCA5);
        chk("scan_dp", bus.dp_out, 4'b0100);
        chk("scan_valid", bus.digit_valid, 4'hF);
        push_ev(2'd2, 1, 4'h0, 1'b0);
        drive(4'hD, 7'h7F, 1'b1, 6);
        drive(4'hF, 7'h7F, 1'b1, 3);
        check_events("miss");
        chk("miss_hex", bus.hex_out, 16'hFCA5);
        chk("miss_valid", bus.digit_valid, 4'hF);
        for (int k = 0; k < 4; k++) drive(4'hE, k[0] ? 7'h24 : 7'h79, 1'b1, 3);
        drive(4'hF, 7'h7F, 1'b1, 3);
        check_events("toggle");
        chk("toggle_hex", bus.hex_out, 16'hFCA5);
        push_ev(2'd1, 3, 4'h4, 1'b0);
        drive(4'h7, 7'h19, 1'b1, 6);
        check_events("tmo_commit");
        drive(4'hF, 7'h7F, 1'b1, T - 2);
        chk("tmo_still_valid", bus.digit_valid[3], 1'b1);
        drive(4'hF, 7'h7F, 1'b1, 5);
        chk("tmo_expired", bus.digit_valid[3], 1'b0);
        chk("tmo_all_expired", bus.digit_valid, 4'h0);
        chk("tmo_nibble_kept", bus.hex_out[15:12], 4'h4);
        drive(4'hB, 7'h30, 1'b1, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("midrst");
        rst = 1'b0;
        m_hex = '0;
        m_dp = '0;
        m_valid = '0;
        push_ev(2'd1, 2, 4'h3, 1'b0);
        drive(4'hB, 7'h30, 1'b1, 6);
        drive(4'hF, 7'h7F, 1'b1, 3);
        check_events("post_rst");
        chk("post_rst_hex", bus.hex_out, 16'h0300);
        chk("post_rst_valid", bus.digit_valid, 4'b0100);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
